// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_st_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_DWID  = 16;
  localparam int DEF_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts one past 'last',
// so the previous winner ends up at lowest priority.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!valid && req[(int'(last) + i) % NREQ]) begin
        valid                              = 1'b1;
        onehot[(int'(last) + i) % NREQ]    = 1'b1;
        idx                                = IW'((int'(last) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter steering up to BURST words per grant from NREQ
// requesters into an external synchronous FIFO; holds no data itself.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int DWID  = DEF_DWID,
  parameter int BURST = DEF_BURST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*DWID-1:0]     wdata_i,
  input  logic                     fifo_full_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic                     fifo_wr_o,
  output logic [DWID-1:0]          fifo_wdata_o,
  output logic [$clog2(NREQ)-1:0]  cur_id_o,
  output logic                     busy_o
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(BURST) + 1;

  arb_st_e         state;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   cur_q;
  logic [IW-1:0]   last_q;
  logic [BW-1:0]   beat_q;

  logic            req_cur;
  logic            beat;
  logic            rel;
  logic            pick_valid;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   pick_last;

  assign req_cur = req_i[cur_q];
  assign beat    = (|(gnt_q & req_i)) & ~fifo_full_i;

  // Release on the last beat of a burst, or as soon as the owner drops its
  // request (even while the FIFO is full); full alone never rotates.
  assign rel = (state == ARB_BUSY) &
               ((beat & (beat_q == BW'(BURST - 1))) | ~req_cur);

  // On release the current owner is the rotation point, so it lands at
  // lowest priority and is regranted only when nobody else is asking.
  assign pick_last = (state == ARB_BUSY) ? cur_q : last_q;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req_i),
    .last   (pick_last),
    .valid  (pick_valid),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      gnt_q  <= '0;
      cur_q  <= '0;
      last_q <= IW'(NREQ - 1);
      beat_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state  <= ARB_BUSY;
            gnt_q  <= pick_oh;
            cur_q  <= pick_idx;
            beat_q <= '0;
          end
        end
        ARB_BUSY: begin
          if (rel) begin
            last_q <= cur_q;
            beat_q <= '0;
            if (pick_valid) begin
              gnt_q <= pick_oh;
              cur_q <= pick_idx;
            end else begin
              state <= ARB_IDLE;
              gnt_q <= '0;
              cur_q <= '0;
            end
          end else if (beat) begin
            beat_q <= beat_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign gnt_o        = gnt_q;
  assign cur_id_o     = cur_q;
  assign busy_o       = |gnt_q;
  assign fifo_wr_o    = beat;
  assign fifo_wdata_o = busy_o ? wdata_i[int'(cur_q)*DWID +: DWID] : '0;

endmodule
